// File: rtl/muu_value_get_wide.sv
// Response formatter: turns hash-table lookup results (command + value lines)
// into a framed {meta, word} stream with optional scan-mode batching.
module muu_value_get_wide #(
  parameter int MEMORY_WIDTH = 512,
  parameter int OUT_WIDTH    = 64,
  parameter int META_WIDTH   = 96,
  parameter int LEN_BITS     = 10,
  parameter int USER_BITS    = 3,
  parameter int MAX_BATCH    = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    cmd_op,
  input  logic [LEN_BITS-1:0]           cmd_len,
  input  logic [USER_BITS-1:0]          cmd_user,
  input  logic [META_WIDTH-1:0]         cmd_meta,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [MEMORY_WIDTH-1:0]       value_data,
  input  logic                          value_valid,
  output logic                          value_ready,
  output logic [META_WIDTH+OUT_WIDTH-1:0] output_data,
  output logic [7:0]                    output_user,
  output logic                          output_valid,
  output logic                          output_last,
  input  logic                          output_ready,
  input  logic                          scan_mode,
  input  logic [31:0]                   stat_data
);

  localparam int WORDS      = MEMORY_WIDTH / OUT_WIDTH;
  localparam int IDX_BITS   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BATCH_BITS = $clog2(MAX_BATCH) + 1;

  localparam logic [3:0]            OP_GET       = 4'd0;
  localparam logic [3:0]            OP_SET_ACK   = 4'd1;
  localparam logic [3:0]            OP_SET_NOACK = 4'd2;
  localparam logic [3:0]            OP_DROP      = 4'd3;
  localparam logic [31:0]           CLOSE_WORD   = 32'hFEEBDAED;
  localparam logic [IDX_BITS-1:0]   IDX_LAST     = IDX_BITS'(WORDS - 1);
  localparam logic [BATCH_BITS-1:0] BATCH_LAST   = BATCH_BITS'(MAX_BATCH - 1);
  localparam logic [LEN_BITS:0]     LINE_ROUND   = (LEN_BITS + 1)'(WORDS - 1);
  localparam logic [LEN_BITS:0]     LINE_DIV     = (LEN_BITS + 1)'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_STAT,
    S_VALUE,
    S_DROP
  } state_t;

  state_t                  state;
  logic [3:0]              op_q;
  logic [LEN_BITS-1:0]     len_q;
  logic [USER_BITS-1:0]    user_q;
  logic [META_WIDTH-1:0]   meta_q;
  logic [LEN_BITS-1:0]     cnt;
  logic [IDX_BITS-1:0]     idx;
  logic [LEN_BITS:0]       drop_left;
  logic [BATCH_BITS-1:0]   batch_cnt;
  logic                    scanning;

  logic                    slot_free;
  logic                    close_pending;
  logic                    close_fire;
  logic                    value_fire;
  logic                    final_word;
  logic [LEN_BITS-1:0]     hdr_len;
  logic [OUT_WIDTH-1:0]    header_word;
  logic [LEN_BITS:0]       drop_lines;
  logic [OUT_WIDTH-1:0]    line_words [WORDS];

  logic                    load;
  logic                    load_natural_last;
  logic                    load_close;
  logic                    load_last;
  logic [OUT_WIDTH-1:0]    load_word;

  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      line_words[k] = value_data[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign slot_free     = !output_valid || output_ready;
  // A falling scan_mode closes the open batch before any new command is taken.
  assign close_pending = scanning && !scan_mode && (state == S_IDLE);
  assign close_fire    = close_pending && slot_free;
  assign cmd_ready     = !rst && cmd_valid && (state == S_IDLE) && slot_free && !close_pending;
  assign value_fire    = (state == S_VALUE) && slot_free && value_valid;
  assign final_word    = (cnt == len_q - 1'b1);
  assign value_ready   = (value_fire && ((idx == IDX_LAST) || final_word)) ||
                         ((state == S_DROP) && value_valid);

  assign hdr_len     = (op_q == OP_GET) ? len_q : '0;
  assign header_word = OUT_WIDTH'({hdr_len, op_q, 16'hFFFF});
  assign drop_lines  = ({1'b0, cmd_len} + LINE_ROUND) / LINE_DIV;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    load              = 1'b0;
    load_natural_last = 1'b0;
    load_close        = 1'b0;
    load_word         = '0;
    case (state)
      S_IDLE: begin
        if (close_fire) begin
          load       = 1'b1;
          load_close = 1'b1;
          load_word  = OUT_WIDTH'(CLOSE_WORD);
        end
      end
      S_HEADER: begin
        if (slot_free) begin
          load              = 1'b1;
          load_word         = header_word;
          load_natural_last = !(((op_q == OP_GET) && (len_q != '0)) || (op_q == OP_SET_ACK));
        end
      end
      S_STAT: begin
        if (slot_free) begin
          load              = 1'b1;
          load_word         = OUT_WIDTH'(stat_data);
          load_natural_last = 1'b1;
        end
      end
      S_VALUE: begin
        if (value_fire) begin
          load              = 1'b1;
          load_word         = line_words[idx];
          load_natural_last = final_word;
        end
      end
      default: ;
    endcase
    load_last = load_close || (scanning ? (batch_cnt >= BATCH_LAST) : load_natural_last);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      len_q        <= '0;
      user_q       <= '0;
      meta_q       <= '0;
      cnt          <= '0;
      idx          <= '0;
      drop_left    <= '0;
      batch_cnt    <= '0;
      scanning     <= 1'b0;
      output_valid <= 1'b0;
      output_last  <= 1'b0;
      output_data  <= '0;
      output_user  <= '0;
    end else begin
      if (load) begin
        output_valid <= 1'b1;
        output_last  <= load_last;
        output_data  <= {meta_q, load_word};
        output_user  <= 8'(user_q);
        if (scanning) begin
          batch_cnt <= load_last ? '0 : batch_cnt + 1'b1;
        end
      end else if (output_ready) begin
        output_valid <= 1'b0;
        output_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (scan_mode) begin
            scanning <= 1'b1;
          end else if (close_fire) begin
            scanning <= 1'b0;
          end
          if (cmd_ready) begin
            op_q      <= cmd_op;
            len_q     <= cmd_len;
            user_q    <= cmd_user;
            meta_q    <= cmd_meta;
            cnt       <= '0;
            idx       <= '0;
            drop_left <= drop_lines;
            state     <= (cmd_op == OP_SET_NOACK) ? S_IDLE : S_HEADER;
          end
        end
        S_HEADER: begin
          if (slot_free) begin
            if ((op_q == OP_GET) && (len_q != '0)) begin
              state <= S_VALUE;
            end else if (op_q == OP_SET_ACK) begin
              state <= S_STAT;
            end else if ((op_q == OP_DROP) && (len_q != '0)) begin
              state <= S_DROP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_STAT: begin
          if (slot_free) begin
            state <= S_IDLE;
          end
        end
        S_VALUE: begin
          if (value_fire) begin
            cnt <= cnt + 1'b1;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (final_word) begin
              state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (value_valid) begin
            drop_left <= drop_left - 1'b1;
            if (drop_left == (LEN_BITS + 1)'(1)) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muu_value_get_wide.sv
// Directed bench for muu_value_get_wide: output beats are captured by a monitor
// and compared against hand-computed headers, value words and frame boundaries.
module tb_muu_value_get_wide;

  localparam int MW  = 512;
  localparam int OW  = 64;
  localparam int MTW = 96;
  localparam int LB  = 10;
  localparam int UB  = 3;

  localparam logic [3:0] OP_GET       = 4'd0;
  localparam logic [3:0] OP_SET_ACK   = 4'd1;
  localparam logic [3:0] OP_SET_NOACK = 4'd2;
  localparam logic [3:0] OP_DROP      = 4'd3;
  localparam logic [3:0] OP_NOP       = 4'd5;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         cmd_op;
  logic [LB-1:0]      cmd_len;
  logic [UB-1:0]      cmd_user;
  logic [MTW-1:0]     cmd_meta;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [MW-1:0]      value_data;
  logic               value_valid;
  logic               value_ready;
  logic [MTW+OW-1:0]  output_data;
  logic [7:0]         output_user;
  logic               output_valid;
  logic               output_last;
  logic               output_ready;
  logic               scan_mode;
  logic [31:0]        stat_data;

  muu_value_get_wide dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .cmd_user     (cmd_user),
    .cmd_meta     (cmd_meta),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .value_data   (value_data),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .output_data  (output_data),
    .output_user  (output_user),
    .output_valid (output_valid),
    .output_last  (output_last),
    .output_ready (output_ready),
    .scan_mode    (scan_mode),
    .stat_data    (stat_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [7:0]        user;
    logic [MTW+OW-1:0] data;
  } beat_t;

  beat_t              out_q[$];
  int                 tests = 0;
  int                 failed = 0;
  int                 vr_cnt = 0;
  int                 line_no = 0;
  int                 stall_err = 0;
  bit                 vr_hs_now = 1'b0;
  logic               prev_stall = 1'b0;
  logic [MTW+OW-1:0]  held_data;
  logic               held_last;

  function automatic logic [OW-1:0] exp_word(input int n, input int k);
    logic [31:0] nn;
    logic [31:0] kk;
    nn = n;
    kk = k;
    return {16'hD00D, nn[15:0], 24'h0, kk[7:0]};
  endfunction

  function automatic logic [MW-1:0] make_line(input int n);
    logic [MW-1:0] l;
    for (int k = 0; k < MW / OW; k++) l[k*OW +: OW] = exp_word(n, k);
    return l;
  endfunction

  // Monitor: everything is sampled mid-cycle, ahead of the edge that acts on it.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      vr_hs_now  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!output_valid || output_data !== held_data || output_last !== held_last))
        stall_err++;
      prev_stall = output_valid && !output_ready;
      held_data  = output_data;
      held_last  = output_last;
      if (output_valid && output_ready) begin
        b.last = output_last;
        b.user = output_user;
        b.data = output_data;
        out_q.push_back(b);
      end
      vr_hs_now = value_valid && value_ready;
      if (vr_hs_now) vr_cnt++;
    end
  end

  // Value source: present the next line once the current one was consumed.
  always @(posedge clk) begin
    #1;
    if (vr_hs_now) begin
      line_no++;
      value_data = make_line(line_no);
      vr_hs_now  = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [LB-1:0] len,
                          input logic [UB-1:0] user, input logic [MTW-1:0] meta);
    int waited;
    cmd_op    = op;
    cmd_len   = len;
    cmd_user  = user;
    cmd_meta  = meta;
    cmd_valid = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL cmd_accept op=%0d: cmd_ready=%b required 1", op, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 4000 && out_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    cmd_op       = OP_GET;
    cmd_len      = 10'd3;
    cmd_user     = '0;
    cmd_meta     = '0;
    cmd_valid    = 1'b1;
    value_valid  = 1'b1;
    value_data   = make_line(0);
    output_ready = 1'b1;
    scan_mode    = 1'b0;
    stat_data    = '0;
    repeat (2) @(negedge clk);
    tests++; if (output_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b required 0", output_valid); end
    tests++; if (output_last !== 1'b0) begin failed++; $display("FAIL reset_last: got %b required 0", output_last); end
    tests++; if (output_data !== '0) begin failed++; $display("FAIL reset_data: got %h required 0", output_data); end
    tests++; if (output_user !== 8'd0) begin failed++; $display("FAIL reset_user: got %h required 0", output_user); end
    tests++; if (cmd_ready !== 1'b0) begin failed++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    tests++; if (value_ready !== 1'b0) begin failed++; $display("FAIL reset_value_ready: got %b required 0", value_ready); end
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_get;
    int    l0;
    int    v0;
    beat_t b;
    logic [OW-1:0] exp;
    logic [MTW-1:0] meta;
    meta = 96'hA5A5_0000_1111_2222_3333_4444;
    out_q.delete();
    l0 = line_no;
    v0 = vr_cnt;
    send_cmd(OP_GET, 10'd11, 3'd5, meta);
    wait_words(12);
    idle(10);
    tests++;
    if (out_q.size() != 12) begin
      failed++;
      $display("FAIL get_count: got %0d words required 12", out_q.size());
    end
    if (out_q.size() >= 12) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_00B0_FFFF || b.last !== 1'b0) begin
        failed++; $display("FAIL get_header: got %h last=%b required 00b0ffff last=0", b.data[OW-1:0], b.last); end
      tests++; if (b.data[MTW+OW-1:OW] !== meta) begin
        failed++; $display("FAIL get_meta: got %h required %h", b.data[MTW+OW-1:OW], meta); end
      tests++; if (b.user !== 8'd5) begin
        failed++; $display("FAIL get_user: got %0d required 5", b.user); end
      for (int j = 1; j <= 11; j++) begin
        b   = out_q[j];
        exp = exp_word(l0 + (j - 1) / 8, (j - 1) % 8);
        tests++;
        if (b.data[OW-1:0] !== exp || b.last !== (j == 11)) begin
          failed++;
          $display("FAIL get_word%0d: got %h last=%b required %h last=%b", j, b.data[OW-1:0], b.last, exp, (j == 11));
        end
      end
    end
    tests++;
    if (vr_cnt - v0 != 2) begin
      failed++; $display("FAIL get_value_ready: got %0d pulses required 2", vr_cnt - v0);
    end
  endtask

  task automatic test_set_ack;
    int    v0;
    beat_t b;
    out_q.delete();
    v0 = vr_cnt;
    stat_data = 32'h0000_1234;
    send_cmd(OP_SET_ACK, 10'd4, 3'd2, 96'h1);
    wait_words(2);
    idle(10);
    tests++;
    if (out_q.size() != 2) begin
      failed++; $display("FAIL set_ack_count: got %0d words required 2", out_q.size());
    end
    if (out_q.size() >= 2) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0001_FFFF || b.last !== 1'b0) begin
        failed++; $display("FAIL set_ack_header: got %h last=%b required 0001ffff last=0", b.data[OW-1:0], b.last); end
      b = out_q[1];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0000_1234 || b.last !== 1'b1) begin
        failed++; $display("FAIL set_ack_stat: got %h last=%b required 1234 last=1", b.data[OW-1:0], b.last); end
    end
    tests++;
    if (vr_cnt != v0) begin
      failed++; $display("FAIL set_ack_value_ready: got %0d pulses required 0", vr_cnt - v0);
    end
  endtask

  task automatic test_set_noack;
    beat_t b;
    out_q.delete();
    send_cmd(OP_SET_NOACK, 10'd9, 3'd1, 96'h2);
    cmd_op    = OP_NOP;
    cmd_len   = 10'd6;
    cmd_user  = 3'd7;
    cmd_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      failed++; $display("FAIL noack_next_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_words(1);
    idle(10);
    tests++;
    if (out_q.size() != 1) begin
      failed++; $display("FAIL noack_count: got %0d words required 1 (NOP header only)", out_q.size());
    end
    if (out_q.size() >= 1) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0005_FFFF || b.last !== 1'b1 || b.user !== 8'd7) begin
        failed++; $display("FAIL nop_header: got %h last=%b user=%0d required 0005ffff last=1 user=7", b.data[OW-1:0], b.last, b.user); end
    end
  endtask

  task automatic test_drop;
    int    v0;
    beat_t b;
    out_q.delete();
    v0 = vr_cnt;
    send_cmd(OP_DROP, 10'd17, 3'd3, 96'h3);
    wait_words(1);
    idle(20);
    tests++;
    if (out_q.size() != 1) begin
      failed++; $display("FAIL drop_count: got %0d words required 1", out_q.size());
    end
    if (out_q.size() >= 1) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0003_FFFF || b.last !== 1'b1) begin
        failed++; $display("FAIL drop_header: got %h last=%b required 0003ffff last=1", b.data[OW-1:0], b.last); end
    end
    tests++;
    if (vr_cnt - v0 != 3) begin
      failed++; $display("FAIL drop_lines: got %0d pulses required 3", vr_cnt - v0);
    end
  endtask

  task automatic test_back_pressure;
    int    l0;
    int    v0;
    int    s0;
    bit    got;
    beat_t b;
    logic [OW-1:0] exp;
    out_q.delete();
    l0 = line_no;
    v0 = vr_cnt;
    s0 = stall_err;
    got = 1'b0;
    cmd_op    = OP_GET;
    cmd_len   = 10'd16;
    cmd_user  = 3'd4;
    cmd_meta  = 96'h4;
    cmd_valid = 1'b1;
    for (int c = 0; c < 600 && out_q.size() < 17; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) got = 1'b1;
      @(posedge clk);
      #1;
      if (got) cmd_valid = 1'b0;
      output_ready = 1'($urandom_range(0, 1));
    end
    cmd_valid    = 1'b0;
    output_ready = 1'b1;
    idle(10);
    tests++;
    if (out_q.size() != 17) begin
      failed++; $display("FAIL bp_count: got %0d words required 17", out_q.size());
    end
    if (out_q.size() >= 17) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0100_FFFF) begin
        failed++; $display("FAIL bp_header: got %h required 0100ffff", b.data[OW-1:0]); end
      for (int j = 1; j <= 16; j++) begin
        b   = out_q[j];
        exp = exp_word(l0 + (j - 1) / 8, (j - 1) % 8);
        tests++;
        if (b.data[OW-1:0] !== exp || b.last !== (j == 16)) begin
          failed++;
          $display("FAIL bp_word%0d: got %h last=%b required %h last=%b", j, b.data[OW-1:0], b.last, exp, (j == 16));
        end
      end
    end
    tests++;
    if (stall_err != s0) begin
      failed++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_err - s0);
    end
    tests++;
    if (vr_cnt - v0 != 2) begin
      failed++; $display("FAIL bp_value_ready: got %0d pulses required 2", vr_cnt - v0);
    end
  endtask

  task automatic test_scan;
    int    l0;
    int    v0;
    int    bad_data;
    int    bad_last;
    beat_t b;
    logic [OW-1:0] exp;
    out_q.delete();
    l0 = line_no;
    v0 = vr_cnt;
    bad_data = 0;
    bad_last = 0;
    scan_mode = 1'b1;
    idle(1);
    for (int g = 0; g < 40; g++) send_cmd(OP_GET, 10'd7, 3'd6, 96'h5);
    wait_words(320);
    idle(5);
    scan_mode = 1'b0;
    wait_words(321);
    idle(10);
    tests++;
    if (out_q.size() != 321) begin
      failed++; $display("FAIL scan_count: got %0d words required 321", out_q.size());
    end
    if (out_q.size() >= 321) begin
      for (int i = 0; i < 320; i++) begin
        b   = out_q[i];
        exp = (i % 8 == 0) ? 64'h0000_0000_0070_FFFF : exp_word(l0 + i / 8, i % 8 - 1);
        if (b.data[OW-1:0] !== exp) bad_data++;
        if (b.last !== (i == 127 || i == 255)) bad_last++;
      end
      tests++; if (bad_data != 0) begin
        failed++; $display("FAIL scan_data: got %0d wrong words required 0", bad_data); end
      tests++; if (bad_last != 0) begin
        failed++; $display("FAIL scan_last: got %0d misplaced last flags required 0", bad_last); end
      b = out_q[320];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_FEEB_DAED || b.last !== 1'b1) begin
        failed++; $display("FAIL scan_close: got %h last=%b required feebdaed last=1", b.data[OW-1:0], b.last); end
    end
    tests++;
    if (vr_cnt - v0 != 40) begin
      failed++; $display("FAIL scan_value_ready: got %0d pulses required 40", vr_cnt - v0);
    end
    // With scanning cleared, a zero-length GET must close its own frame.
    out_q.delete();
    send_cmd(OP_GET, 10'd0, 3'd1, 96'h6);
    wait_words(1);
    idle(10);
    tests++;
    if (out_q.size() != 1) begin
      failed++; $display("FAIL post_scan_count: got %0d words required 1", out_q.size());
    end
    if (out_q.size() >= 1) begin
      b = out_q[0];
      tests++; if (b.data[OW-1:0] !== 64'h0000_0000_0000_FFFF || b.last !== 1'b1) begin
        failed++; $display("FAIL post_scan_header: got %h last=%b required 0000ffff last=1", b.data[OW-1:0], b.last); end
    end
  endtask

  initial begin
    test_reset();
    test_get();
    test_set_ack();
    test_set_noack();
    test_drop();
    test_back_pressure();
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muu_value_get_wide.md
Name: muu_value_get_wide

Overview:
- Parametrised successor to the MUU value-get formatter. Turns hash-table lookup results (command plus optional value lines from memory) into a framed response stream.
- Memory line width, output word width and value length are generic. Adds value drop, no-ack writes, a stat word, and scan batching with a forced close word.
- Sits between the hash-table/value-fetch pipeline and the response packetiser.

Parameters:
- MEMORY_WIDTH, 512, width of a value line from memory.
- OUT_WIDTH, 64, output word width; must divide MEMORY_WIDTH; must be ≥ 48.
- META_WIDTH, 96, opaque per-request metadata carried on every output word.
- LEN_BITS, 10, value length field, counted in OUT_WIDTH words.
- USER_BITS, 3, user id width; zero-extended to 8 on output_user.
- MAX_BATCH, 128, maximum words per frame in scan mode.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_op  in  4  0=GET, 1=SET_ACK, 2=SET_NOACK, 3=DROP, others=NOP
- cmd_len  in  LEN_BITS  value length in OUT_WIDTH words
- cmd_user  in  USER_BITS  requester id
- cmd_meta  in  META_WIDTH  metadata
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted this cycle
- value_data  in  MEMORY_WIDTH  value line; word k is [k*OUT_WIDTH +: OUT_WIDTH]
- value_valid  in  1  value line valid
- value_ready  out  1  value line consumed this cycle
- output_data  out  META_WIDTH+OUT_WIDTH  {meta, word}
- output_user  out  8  user id of the current frame
- output_valid  out  1  output valid
- output_last  out  1  end of frame
- output_ready  in  1  downstream ready
- scan_mode  in  1  batch responses into multi-response frames
- stat_data  in  32  allocator status, sampled when the stat word is emitted

Behaviour:
- Reset (async, immediate):
  - output_valid, output_last, cmd_ready, value_ready = 0.
  - output_data, output_user = 0.
  - State = IDLE; word counter = 0; batch counter = 0; scanning = 0.
- Output register: a new word may load when !output_valid or (output_valid && output_ready), giving full throughput. Data is held stable while output_valid && !output_ready.
- cmd_ready: combinational; = cmd_valid && state==IDLE && output slot free.
- On accept:
  - Latch op, len, user, meta.
  - Header loads next cycle: word = {0, len', op, 16'hFFFF}. len' = cmd_len for GET, 0 for DROP/SET/NOP.
  - SET_NOACK produces no output.
- States:
  - IDLE → HEADER on accept (SET_NOACK: stays IDLE).
  - HEADER (emitting header):
    - GET with len>0 → VALUE.
    - SET_ACK → STAT.
    - DROP with len>0 → DROP.
    - Otherwise header carries last; → IDLE.
  - STAT: emit {0, stat_data} with last; → IDLE.
  - VALUE: per slot, emit word idx of the current line (requires value_valid); idx wraps at MEMORY_WIDTH/OUT_WIDTH.
    - value_ready pulses when idx wraps or on the final word, so a partial final line is consumed and its remainder discarded.
    - Final word (count==len) carries last; → IDLE.
  - DROP: consume ceil(len*OUT_WIDTH/MEMORY_WIDTH) lines, one per value_valid cycle, with no output; → IDLE.
- Scan batching (scanning latched from scan_mode in IDLE):
  - If scanning, last is asserted only when batch counter ≥ MAX_BATCH−1; the counter resets after each last.
  - If scan_mode falls while scanning, with no pending last and state IDLE, emit close word {0, 32'hFEEBDAED} with last; scanning clears.
- Simultaneous events: cmd_valid arriving while the close word is pending waits for the close word to be emitted first.
- Reset mid-frame abandons the frame; value lines not yet consumed remain upstream.

Test Plan:
- GET len=11, MEMORY_WIDTH=512 → header {len=11, op=0, FFFF}, 11 value words from two lines, value_ready pulses after words 8 and 11, last on word 11.
- SET_ACK with stat_data=0x1234 → header len=0 op=1, then 0x1234 with last; no value_ready.
- SET_NOACK → cmd_ready pulse, zero output words, next command accepted the following cycle.
- DROP len=17 → header len=0 with last; exactly 3 value_ready pulses; nothing else output.
- output_ready toggled randomly during GET len=16 → no word lost or duplicated; data stable while stalled.
- scan_mode=1, 40 GETs of len=7 (8 words each) → last only on words 128 and 256; scan_mode→0 → close word 0xFEEBDAED with last.
